// File: rtl/scan_sequencer.sv
// Digit-scan sequencer driving a 2-to-4 digit-select decoder: SHOW/BLANK dwell per digit, frame pulse on wrap.
// Optional macro SCAN_DIGIT_MASK_EN adds a Mask[3:0] input that skips disabled digits.
module scan_sequencer #(
  parameter int DIV   = 50000,
  parameter int BLANK = 8,
  parameter int CNT_W = 16
) (
  input  logic       Clock,
  input  logic       Reset,
  input  logic       Run,
`ifdef SCAN_DIGIT_MASK_EN
  input  logic [3:0] Mask,
`endif
  output logic [1:0] w,
  output logic       E,
  output logic       frame
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHOW  = 2'd1,
    ST_BLANK = 2'd2
  } state_t;

  localparam logic [CNT_W-1:0] DIV_LAST   = CNT_W'(DIV - 1);
  localparam logic [CNT_W-1:0] BLANK_LAST = (BLANK > 0) ? CNT_W'(BLANK - 1) : '0;
  localparam bit               HAS_BLANK  = (BLANK > 0);

  state_t           state_q, state_d;
  logic [1:0]       w_q, w_d;
  logic             e_q, e_d;
  logic             frame_q, frame_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [3:0]       mask_v;
  logic [1:0]       w_next;
  logic [1:0]       w_first;

`ifdef SCAN_DIGIT_MASK_EN
  assign mask_v = Mask;
`else
  assign mask_v = 4'b1111;
`endif

  // Nearest enabled index above cur, wrapping; offset 4 lands back on cur itself.
  function automatic logic [1:0] next_enabled(input logic [1:0] cur, input logic [3:0] m);
    logic [1:0] idx;
    next_enabled = cur;
    for (int i = 4; i >= 1; i--) begin
      idx = cur + 2'(i);
      if (m[idx]) next_enabled = idx;
    end
  endfunction

  function automatic logic [1:0] first_enabled(input logic [3:0] m);
    first_enabled = 2'd0;
    for (int i = 3; i >= 0; i--) begin
      if (m[i]) first_enabled = 2'(i);
    end
  endfunction

  assign w_next  = next_enabled(w_q, mask_v);
  assign w_first = first_enabled(mask_v);

  always_comb begin
    state_d = state_q;
    w_d     = w_q;
    e_d     = e_q;
    frame_d = 1'b0;
    cnt_d   = cnt_q;

    // Stopping, or having nothing to show, abandons any partial dwell.
    if (!Run || (mask_v == 4'b0000)) begin
      state_d = ST_IDLE;
      w_d     = 2'd0;
      e_d     = 1'b0;
      cnt_d   = '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          state_d = ST_SHOW;
          w_d     = w_first;
          e_d     = 1'b1;
          cnt_d   = '0;
        end
        ST_SHOW: begin
          e_d = 1'b1;
          if (cnt_q == DIV_LAST) begin
            cnt_d = '0;
            if (HAS_BLANK) begin
              state_d = ST_BLANK;
              e_d     = 1'b0;
            end else begin
              w_d     = w_next;
              frame_d = (w_next <= w_q);
            end
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
        ST_BLANK: begin
          e_d = 1'b0;
          if (cnt_q == BLANK_LAST) begin
            cnt_d   = '0;
            state_d = ST_SHOW;
            e_d     = 1'b1;
            w_d     = w_next;
            frame_d = (w_next <= w_q);
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
        default: begin
          state_d = ST_IDLE;
          w_d     = 2'd0;
          e_d     = 1'b0;
          cnt_d   = '0;
        end
      endcase
    end
  end

  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      state_q <= ST_IDLE;
      w_q     <= 2'd0;
      e_q     <= 1'b0;
      frame_q <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      w_q     <= w_d;
      e_q     <= e_d;
      frame_q <= frame_d;
      cnt_q   <= cnt_d;
    end
  end

  assign w     = w_q;
  assign E     = e_q;
  assign frame = frame_q;

endmodule

// File: tb/tb_scan_sequencer.sv
// Directed bench for scan_sequencer: one cycle-by-cycle vector table plus hand sequences
// for no-blank, DIV=1, reset-mid-dwell and (with SCAN_DIGIT_MASK_EN) masked scanning.
module tb_scan_sequencer;

  typedef struct {
    logic       run;
    logic [1:0] w;
    logic       e;
    logic       f;
  } vec_t;

  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic       run_a = 1'b0;
  logic       run_b = 1'b0;
  logic       run_c = 1'b0;
  logic [1:0] w_a, w_b, w_c;
  logic       e_a, e_b, e_c;
  logic       f_a, f_b, f_c;
`ifdef SCAN_DIGIT_MASK_EN
  logic [3:0] mask_a = 4'b1111;
  logic [3:0] mask_b = 4'b1111;
  logic [3:0] mask_c = 4'b1111;
`endif

  int   checks   = 0;
  int   failures = 0;
  vec_t tbl[$];

  always #5 clock = ~clock;

  scan_sequencer #(.DIV(4), .BLANK(2), .CNT_W(16)) dut_a (
    .Clock(clock), .Reset(reset), .Run(run_a),
`ifdef SCAN_DIGIT_MASK_EN
    .Mask(mask_a),
`endif
    .w(w_a), .E(e_a), .frame(f_a)
  );

  scan_sequencer #(.DIV(3), .BLANK(0), .CNT_W(16)) dut_b (
    .Clock(clock), .Reset(reset), .Run(run_b),
`ifdef SCAN_DIGIT_MASK_EN
    .Mask(mask_b),
`endif
    .w(w_b), .E(e_b), .frame(f_b)
  );

  scan_sequencer #(.DIV(1), .BLANK(1), .CNT_W(16)) dut_c (
    .Clock(clock), .Reset(reset), .Run(run_c),
`ifdef SCAN_DIGIT_MASK_EN
    .Mask(mask_c),
`endif
    .w(w_c), .E(e_c), .frame(f_c)
  );

  task automatic add(input logic r, input int wv, input logic e, input logic f, input int n);
    vec_t v;
    v.run = r;
    v.w   = 2'(wv);
    v.e   = e;
    v.f   = f;
    for (int k = 0; k < n; k++) tbl.push_back(v);
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic check_output(input string name, input logic [1:0] gw, input logic ge, input logic gf,
                              input logic [1:0] xw, input logic xe, input logic xf);
    checks++;
    if ({gw, ge, gf} !== {xw, xe, xf}) begin
      failures++;
      $display("[TB] FAIL %s: got w=%0d E=%0b frame=%0b, expected w=%0d E=%0b frame=%0b",
               name, gw, ge, gf, xw, xe, xf);
    end
  endtask

  initial begin
    // Expected outputs of dut_a (DIV=4, BLANK=2) after each edge, starting at the edge that sees Run=1.
    add(1, 0, 1, 0, 4);
    add(1, 0, 0, 0, 2);
    add(1, 1, 1, 0, 4);
    add(1, 1, 0, 0, 2);
    add(1, 2, 1, 0, 4);
    add(1, 2, 0, 0, 2);
    add(1, 3, 1, 0, 4);
    add(1, 3, 0, 0, 2);
    add(1, 0, 1, 1, 1);
    add(1, 0, 1, 0, 3);
    add(1, 0, 0, 0, 2);
    add(1, 1, 1, 0, 4);
    add(1, 1, 0, 0, 2);
    add(1, 2, 1, 0, 2);
    add(0, 0, 0, 0, 2);
    add(1, 0, 1, 0, 4);
    add(1, 0, 0, 0, 2);
    add(1, 1, 1, 0, 1);

    #3;
    check_output("reset_a", w_a, e_a, f_a, 2'd0, 1'b0, 1'b0);
    check_output("reset_b", w_b, e_b, f_b, 2'd0, 1'b0, 1'b0);
    check_output("reset_c", w_c, e_c, f_c, 2'd0, 1'b0, 1'b0);
    tick();
    reset = 1'b0;
    tick();
    check_output("idle_a", w_a, e_a, f_a, 2'd0, 1'b0, 1'b0);

    for (int i = 0; i < tbl.size(); i++) begin
      run_a = tbl[i].run;
      tick();
      check_output($sformatf("scan_a[%0d]", i), w_a, e_a, f_a, tbl[i].w, tbl[i].e, tbl[i].f);
    end

    // No blanking: E held high, digit steps every 3 clocks, frame on the 3->0 step.
    run_b = 1'b1;
    for (int i = 0; i < 15; i++) begin
      tick();
      check_output($sformatf("noblank_b[%0d]", i), w_b, e_b, f_b, 2'((i / 3) % 4), 1'b1, (i == 12));
    end

    // Single-cycle SHOW and BLANK alternate.
    run_c = 1'b1;
    for (int i = 0; i < 17; i++) begin
      tick();
      check_output($sformatf("div1_c[%0d]", i), w_c, e_c, f_c, 2'((i / 2) % 4), (i % 2 == 0),
                   (i == 8) || (i == 16));
    end

    // Asynchronous reset between edges while dut_a shows digit 2.
    run_a = 1'b0;
    tick();
    run_a = 1'b1;
    for (int i = 0; i < 13; i++) tick();
    check_output("pre_reset_a", w_a, e_a, f_a, 2'd2, 1'b1, 1'b0);
    #2 reset = 1'b1;
    #1;
    check_output("async_reset_a", w_a, e_a, f_a, 2'd0, 1'b0, 1'b0);
    check_output("async_reset_b", w_b, e_b, f_b, 2'd0, 1'b0, 1'b0);
    #1 reset = 1'b0;
    tick();
    check_output("restart_a", w_a, e_a, f_a, 2'd0, 1'b1, 1'b0);

`ifdef SCAN_DIGIT_MASK_EN
    // Mask 1010: only digits 1 and 3 scanned, frame on 3->1.
    run_a  = 1'b0;
    mask_a = 4'b1010;
    tick();
    run_a = 1'b1;
    for (int i = 0; i < 13; i++) begin
      tick();
      check_output($sformatf("mask_a[%0d]", i), w_a, e_a, f_a,
                   (i >= 6 && i < 12) ? 2'd3 : 2'd1, (i % 6) < 4, (i == 12));
    end
    mask_a = 4'b0000;
    tick();
    check_output("mask_zero_a", w_a, e_a, f_a, 2'd0, 1'b0, 1'b0);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/scan_sequencer.md
Name: scan_sequencer

Overview:
- Upstream driver for the 2-to-4 digit-select decoder. Generates the select code w[1:0] and decoder enable E that time-multiplex four display digits.
- Each digit is held for DIV clocks (SHOW), followed by BLANK clocks with E low (anti-ghosting), then the select advances. The select wraps 3->0.
- Outputs w and E connect directly to the decoder's w and E inputs.

Parameters:
- DIV, 50000, clocks per digit in SHOW; legal range 1..2^CNT_W-1.
- BLANK, 8, blanking clocks between digits; 0 means no blanking gap.
- CNT_W, 16, width of the internal dwell/blank counter; must hold max(DIV, BLANK).

Ports:
- Clock  in  1  system clock; all state changes on the rising edge.
- Reset  in  1  asynchronous, active-high reset.
- Run  in  1  1 = scan, 0 = stop and blank.
- w  out  2  digit select code to the decoder (registered).
- E  out  1  decoder enable; high only in SHOW (registered).
- frame  out  1  one-clock pulse when the select wraps from 3 to 0 (registered).

Behaviour:
- Reset (async, active-high): state=IDLE, w=2'b00, E=0, frame=0, counter=0. Reset takes effect immediately, including mid-SHOW or mid-BLANK.
- All outputs come from flops. There is no combinational path from Run to any output.
- IDLE: E=0, w=0, counter=0. When Run=1 at a clock edge, the next state is SHOW with w=0, E=1, counter=0.
- SHOW:
  - E=1 and the counter increments each clock.
  - When counter==DIV-1, the counter clears. If BLANK>0, go to BLANK with E=0 on the next cycle.
  - If BLANK==0, advance w directly and stay in SHOW; E stays high continuously.
  - Each digit is therefore held with E=1 for exactly DIV clocks.
- BLANK:
  - E=0, w holds the previous digit, and the counter increments.
  - When counter==BLANK-1, the counter clears, w advances to w+1 (mod 4), and the state returns to SHOW with E=1.
- Advancing w: frame=1 for exactly the one cycle in which w becomes 0 from 3; frame=0 otherwise. The initial IDLE->SHOW entry does not pulse frame.
- Frame period: 4*(DIV+BLANK) clocks.
- Run=0 in any state: the next edge goes to IDLE with E=0, w=0, counter=0, frame=0. A partial dwell is abandoned, not completed.
- Run re-asserted: scanning always restarts at digit 0 with a full DIV dwell.
- DIV=1: each SHOW lasts a single cycle.
- Counter arithmetic is unsigned CNT_W-bit. Terminal compares use DIV-1 and BLANK-1 truncated to CNT_W.

Optional Feature:
- Macro: SCAN_DIGIT_MASK_EN.
- When defined:
  - Adds input port Mask [3:0] (1 = digit enabled), sampled on every advance.
  - Advance selects the next enabled index above the current w, wrapping; disabled digits receive neither SHOW nor BLANK time.
  - Leaving IDLE selects the lowest enabled index.
  - frame pulses whenever the new w is less than or equal to the old w, i.e. a wrap.
  - If Mask==0, the block behaves as IDLE (E=0, w=0) until a bit is set.
  - A single enabled digit gives SHOW/BLANK alternation on that index, with frame pulsing on each advance.
- When undefined: no Mask port, and all four digits are scanned in order 0,1,2,3.

Test Plan:
- Reset mid-operation: Reset=1 asserted between clock edges during SHOW with w=2 -> w=0, E=0, frame=0 immediately, before the next edge.
- Basic scan (DIV=4, BLANK=2): Run=1 at edge 0 -> the following sequence repeats with a 24-clock period:
  - E=1,w=0 at edges 1-4; E=0,w=0 at edges 5-6.
  - E=1,w=1 at edges 7-10; E=0,w=1 at edges 11-12.
  - E=1,w=2 at edges 13-16; E=0,w=2 at edges 17-18.
  - E=1,w=3 at edges 19-22; E=0,w=3 at edges 23-24.
  - E=1,w=0 with frame=1 at edge 25 only.
- No blanking (DIV=3, BLANK=0): Run=1 -> E stays 1 continuously; w steps 0,1,2,3,0 every 3 clocks; frame pulses every 12 clocks.
- Stop mid-dwell: Run dropped during the 2nd cycle of w=2 SHOW -> next edge E=0, w=0. Run re-raised -> E=1, w=0 for a full 4 cycles.
- DIV=1, BLANK=1: E toggles 1,0,1,0; w advances every 2 clocks; frame every 8 clocks.
- With SCAN_DIGIT_MASK_EN, Mask=4'b1010, DIV=4, BLANK=2:
  - Scan sequence is w=1 then w=3, repeating with a 12-clock period; w=0 and w=2 never appear.
  - frame pulses on each 3->1 transition.
  - Changing Mask to 4'b0000 -> E=0, w=0 on the next edge.
